// File: rtl/vga_frame_capture_if.sv
// rtl/vga_frame_capture_if.sv - video sample stream and frame memory write port
//
// Purpose: bundles the sampled VGA stream and the frame memory write port of
// vga_frame_capture into one interface.
// Ports (signals):
//   pix_ce             pixel strobe; video signals are valid only while high
//   r, g, b            pixel colour, 8 bits each
//   hsync, vsync       sync, active-low
//   n_blanc            high while the pixel is visible
//   mem_we             frame memory write strobe
//   mem_addr           frame memory write address (ADDR_W bits)
//   mem_wdata          pixel as {r,g,b}
// Modports: master = capture block (consumes video, drives memory),
//           slave  = video source / memory side.

interface vga_frame_capture_if #(
   parameter int ADDR_W = 19
);
   logic              pix_ce;
   logic [7:0]        r;
   logic [7:0]        g;
   logic [7:0]        b;
   logic              hsync;
   logic              vsync;
   logic              n_blanc;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [23:0]       mem_wdata;

   modport master (
      input  pix_ce, r, g, b, hsync, vsync, n_blanc,
      output mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output pix_ce, r, g, b, hsync, vsync, n_blanc,
      input  mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/vga_frame_capture.sv
// rtl/vga_frame_capture.sv - VGA stream capture into frame memory with geometry check
//
// Purpose: samples the VGA stream on pix_ce, writes every visible pixel of one
// armed frame to external memory, flags line/frame geometry violations and
// keeps a per-frame checksum.
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   bus (master)       video samples in, frame memory writes out
//   arm                one-cycle request to capture the next full frame
//   busy               high while waiting for vsync or capturing
//   done               one-cycle pulse when a capture ends
//   line_err           sticky: a line was not exactly H_ACTIVE pixels
//   frame_err          sticky: the frame ended before V_ACTIVE lines
//   lines              visible lines captured in the current/last frame
//   checksum           running frame checksum
// Configuration: define VGA_CAP_CHECKSUM_EN to build the checksum; otherwise
// checksum is tied to 0.

module vga_frame_capture #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int ADDR_W   = 19
) (
   input  logic                clk,
   input  logic                rst,
   vga_frame_capture_if.master bus,
   input  logic                arm,
   output logic                busy,
   output logic                done,
   output logic                line_err,
   output logic                frame_err,
   output logic [9:0]          lines,
   output logic [31:0]         checksum
);
   localparam int                X_W    = $clog2(H_ACTIVE + 1);
   localparam logic [X_W-1:0]    X_END  = X_W'(H_ACTIVE);
   localparam logic [9:0]        V_LAST = 10'(V_ACTIVE);
   localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_ACTIVE);

   typedef enum logic [1:0] {IDLE, SYNC_WAIT, CAPTURE, DONE} state_t;

   state_t            state, state_next;
   logic [X_W-1:0]    x;
   logic [X_W-1:0]    x_after;
   logic [ADDR_W-1:0] line_base;
   logic              prev_vsync, prev_hsync, prev_nblanc;
   logic              vs_fall, hs_fall, nb_fall;
   logic              in_cap, pix_vis, pix_wr, line_end, frame_end, start;
   logic              set_line_err, set_frame_err;
   logic [9:0]        lines_inc;

   // Edges compare against the previous pix_ce sample, not the previous clk.
   always_comb begin
      vs_fall       = bus.pix_ce & prev_vsync & ~bus.vsync;
      hs_fall       = bus.pix_ce & prev_hsync & ~bus.hsync;
      nb_fall       = bus.pix_ce & prev_nblanc & ~bus.n_blanc;
      start         = (state == IDLE) & arm;
      in_cap        = (state == CAPTURE) & bus.pix_ce;
      pix_vis       = in_cap & bus.n_blanc;
      pix_wr        = pix_vis & (x < X_END);
      x_after       = x + X_W'(pix_wr);
      // A vsync fall in the middle of a visible line also closes that line.
      line_end      = in_cap & (nb_fall | (vs_fall & bus.n_blanc));
      lines_inc     = lines + {9'd0, line_end};
      frame_end     = in_cap & (vs_fall | (line_end & (lines_inc == V_LAST)));
      set_line_err  = (pix_vis & ~(x < X_END))
                    | (line_end & (x_after != X_END))
                    | (in_cap & hs_fall & bus.n_blanc);
      set_frame_err = in_cap & vs_fall & (lines_inc < V_LAST);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE:      if (arm) state_next = SYNC_WAIT;
         SYNC_WAIT: begin
            busy = 1'b1;
            if (vs_fall) state_next = CAPTURE;
         end
         CAPTURE:   begin
            busy = 1'b1;
            if (frame_end) state_next = DONE;
         end
         DONE:      begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         prev_vsync    <= 1'b0;
         prev_hsync    <= 1'b0;
         prev_nblanc   <= 1'b0;
         x             <= '0;
         line_base     <= '0;
         lines         <= '0;
         line_err      <= 1'b0;
         frame_err     <= 1'b0;
      end else begin
         bus.mem_we <= pix_wr;
         if (bus.pix_ce) begin
            prev_vsync  <= bus.vsync;
            prev_hsync  <= bus.hsync;
            prev_nblanc <= bus.n_blanc;
         end
         if (start) begin
            x         <= '0;
            line_base <= '0;
            lines     <= '0;
            line_err  <= 1'b0;
            frame_err <= 1'b0;
         end else if (in_cap) begin
            if (pix_wr) begin
               bus.mem_addr  <= line_base + ADDR_W'(x);
               bus.mem_wdata <= {bus.r, bus.g, bus.b};
            end
            // x stops at H_ACTIVE on long lines since pix_wr is then low.
            if (line_end) begin
               x         <= '0;
               line_base <= line_base + H_STEP;
               lines     <= lines_inc;
            end else begin
               x <= x_after;
            end
            if (set_line_err)  line_err  <= 1'b1;
            if (set_frame_err) frame_err <= 1'b1;
         end
      end
   end

`ifdef VGA_CAP_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        checksum <= '0;
      else if (start)  checksum <= '0;
      else if (pix_wr) checksum <= {checksum[30:0], checksum[31]}
                                   + {8'h00, bus.r, bus.g, bus.b};
   end
`else
   assign checksum = '0;
`endif
endmodule

// File: tb/tb_vga_frame_capture.sv
// tb/tb_vga_frame_capture.sv - scoreboard bench for vga_frame_capture on a 4x3 frame
module tb_vga_frame_capture;
   localparam int H  = 4;
   localparam int V  = 3;
   localparam int AW = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        arm = 1'b0;
   logic        busy, done, line_err, frame_err;
   logic [9:0]  lines;
   logic [31:0] checksum;

   vga_frame_capture_if #(.ADDR_W(AW)) bus ();

   vga_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .bus(bus.master), .arm(arm), .busy(busy),
      .done(done), .line_err(line_err), .frame_err(frame_err),
      .lines(lines), .checksum(checksum)
   );

   always #5 clk = ~clk;

   typedef struct {logic [AW-1:0] addr; logic [23:0] data;} wr_t;
   typedef struct {int nl; bit lerr; bit ferr; logic [31:0] cks;} st_t;

   wr_t         wq[$];
   st_t         sq[$];
   wr_t         ew;
   st_t         es;
   int          total   = 0;
   int          passed  = 0;
   int          wr_seen = 0;
   int          max_gap = 0;
   int          lens[V];
   logic [23:0] pix[V][6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Scoreboard monitor: compares every write and every done pulse.
   initial forever begin
      @(negedge clk);
      if (bus.mem_we === 1'b1) begin
         wr_seen++;
         if (wq.size() == 0) chk("unexpected_write", 1, 0);
         else begin
            ew = wq.pop_front();
            chk("wr_addr", 32'(bus.mem_addr), 32'(ew.addr));
            chk("wr_data", 32'(bus.mem_wdata), 32'(ew.data));
         end
      end
      if (done === 1'b1) begin
         if (sq.size() == 0) chk("unexpected_done", 1, 0);
         else begin
            es = sq.pop_front();
            chk("lines", 32'(lines), 32'(es.nl));
            chk("line_err", 32'(line_err), 32'(es.lerr));
            chk("frame_err", 32'(frame_err), 32'(es.ferr));
            chk("checksum", checksum, es.cks);
            chk("busy_at_done", 32'(busy), 0);
         end
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         bus.pix_ce = 1'b0;
      end
   endtask

   // One pix_ce sample, preceded by random non-strobe cycles carrying junk.
   task automatic sample(input bit vs, input bit hs, input bit nb, input logic [23:0] rgb);
      int gap;
      gap = $urandom_range(0, max_gap);
      for (int i = 0; i < gap; i++) begin
         @(posedge clk); #1;
         bus.pix_ce  = 1'b0;
         bus.vsync   = 1'($urandom);
         bus.hsync   = 1'($urandom);
         bus.n_blanc = 1'($urandom);
         {bus.r, bus.g, bus.b} = 24'($urandom);
      end
      @(posedge clk); #1;
      bus.pix_ce  = 1'b1;
      bus.vsync   = vs;
      bus.hsync   = hs;
      bus.n_blanc = nb;
      {bus.r, bus.g, bus.b} = rgb;
   endtask

   task automatic send_frame(input int nl);
      sample(1, 1, 0, 0); sample(0, 1, 0, 0); sample(0, 1, 0, 0); sample(1, 1, 0, 0);
      for (int l = 0; l < nl; l++) begin
         sample(1, 0, 0, 0); sample(1, 1, 0, 0);
         for (int i = 0; i < lens[l]; i++) sample(1, 1, 1, pix[l][i]);
         sample(1, 1, 0, 0);
      end
      sample(1, 1, 0, 0); sample(0, 1, 0, 0); sample(1, 1, 0, 0);
      idle(2);
   endtask

   // Reference: line l pixel i lands at l*H+i; excess pixels are dropped.
   task automatic expect_frame(input int nl);
      int          nv;
      bit          le;
      logic [31:0] c;
      nv = (nl < V) ? nl : V;
      le = 1'b0;
      c  = 32'd0;
      for (int l = 0; l < nv; l++) begin
         if (lens[l] != H) le = 1'b1;
         for (int i = 0; i < lens[l] && i < H; i++) begin
            wq.push_back('{addr: AW'(l * H + i), data: pix[l][i]});
            c = ((c << 1) | (c >> 31)) + {8'h00, pix[l][i]};
         end
      end
`ifndef VGA_CAP_CHECKSUM_EN
      c = 32'd0;
`endif
      sq.push_back('{nl: nv, lerr: le, ferr: (nl < V), cks: c});
   endtask

   task automatic arm_pulse();
      @(posedge clk); #1;
      arm = 1'b1; bus.pix_ce = 1'b1; bus.vsync = 1'b1; bus.hsync = 1'b1; bus.n_blanc = 1'b0;
      @(posedge clk); #1;
      arm = 1'b0; bus.pix_ce = 1'b0;
      chk("busy_armed", 32'(busy), 1);
   endtask

   task automatic drain();
      int k;
      for (k = 0; k < 300; k++) begin
         if (wq.size() == 0 && sq.size() == 0) break;
         @(posedge clk);
      end
      chk("drain_pending", 32'(wq.size() + sq.size()), 0);
   endtask

   task automatic run_frame(input int nl);
      arm_pulse();
      expect_frame(nl);
      send_frame(nl);
      drain();
   endtask

   task automatic fill(input int mode);
      for (int l = 0; l < V; l++)
         for (int i = 0; i < 6; i++)
            pix[l][i] = (mode == 0) ? 24'(l * H + i) : (mode == 1) ? 24'h000001 : 24'($urandom);
   endtask

   task automatic set_lens(input int a, input int b, input int c);
      lens[0] = a; lens[1] = b; lens[2] = c;
   endtask

   initial begin
      int target;
      int k;
      bus.pix_ce = 1'b0; bus.vsync = 1'b1; bus.hsync = 1'b1; bus.n_blanc = 1'b0;
      {bus.r, bus.g, bus.b} = 24'd0;
      idle(3);
      chk("rst_mem_we", 32'(bus.mem_we), 0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 0);
      chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_line_err", 32'(line_err), 0);
      chk("rst_frame_err", 32'(frame_err), 0);
      chk("rst_lines", 32'(lines), 0);
      chk("rst_checksum", checksum, 0);
      rst = 1'b1;
      idle(2);

      max_gap = 0; fill(0); set_lens(4, 4, 4); run_frame(3);
      max_gap = 1; fill(2); set_lens(4, 3, 4); run_frame(3);
      fill(2); set_lens(5, 4, 4); run_frame(3);
      fill(2); set_lens(4, 4, 4); run_frame(2);
      max_gap = 0; fill(1); set_lens(4, 4, 4); run_frame(3);

      for (int f = 0; f < 6; f++) begin
         max_gap = $urandom_range(0, 2);
         fill(2);
         for (int l = 0; l < V; l++) lens[l] = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 5) : H;
         run_frame($urandom_range(1, V));
      end

      max_gap = 0; fill(2); set_lens(4, 4, 4);
      arm_pulse();
      expect_frame(3);
      fork
         send_frame(3);
         begin
            target = wr_seen + 5;
            for (k = 0; k < 500 && wr_seen < target; k++) begin
               @(negedge clk); #1;
            end
            chk("reset_wait", 32'(wr_seen >= target), 1);
            rst = 1'b0;
            wq.delete();
            sq.delete();
            #1;
            chk("midrst_mem_we", 32'(bus.mem_we), 0);
            chk("midrst_mem_addr", 32'(bus.mem_addr), 0);
            chk("midrst_busy", 32'(busy), 0);
            chk("midrst_lines", 32'(lines), 0);
            chk("midrst_line_err", 32'(line_err), 0);
            chk("midrst_checksum", checksum, 0);
         end
      join
      rst = 1'b1;
      idle(2);
      fill(0); set_lens(4, 4, 4); run_frame(3);

      idle(4);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
